syscall_console: RTL and testbench

//  Operator-side responder to the CPU SYSCALL halt/display/GO handshake. Shows the CPU display word
//  on an 8-digit multiplexed 7-segment display, freezes it when the CPU halts on SYSCALL, and issues
//  a one-cycle GO pulse on a debounced button press. Sits at board top between the pipeline CPU
//  top and the board pins.

---
 rtl/syscall_console_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 55 +++++
 rtl/syscall_console.sv | 139 +++++++++++++
 tb/tb_syscall_console.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_console_pkg.sv
// Shared types and constants for the SYSCALL operator console.
// Holds the console FSM encoding and the active-low hex segment table.
// No logic of its own; imported by syscall_console and btn_debounce.
package syscall_console_pkg;

    // 2'd3 is unused and maps back to ST_RUN.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Active-low {dp,g,f,e,d,c,b,a}, entry n shows hex digit n (dp off).
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debouncer producing a clean level and a press pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples, then level/rise registered.
// No backpressure: free-running, one-cycle rise pulse per accepted 0->1 transition.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   btn_raw in   raw asynchronous button
//   level   out  debounced button level
//   rise    out  one-cycle pulse when level goes 0->1
module btn_debounce
    import syscall_console_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the run, so bounce never accumulates.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/syscall_console.sv
// Operator console for the CPU SYSCALL halt/display/GO handshake with 8-digit 7-seg scan.
// Latency: GO registered one cycle after a debounced press; an/seg registered with the scan index.
// No backpressure: GO is a one-cycle pulse, never asserted two cycles in a row.
//
// Ports:
//   clk            in   system clock
//   CLR            in   synchronous active-high reset, wins over everything
//   display[31:0]  in   CPU display word
//   halt           in   CPU halted on SYSCALL (level)
//   btn_go         in   raw push-button, active-high
//   GO             out  one-cycle resume pulse
//   an[7:0]        out  active-low digit enables, an[i] = digit i
//   seg[7:0]       out  active-low segments {dp,g,f,e,d,c,b,a}
//   halted_led     out  high while not in RUN
//   syscall_count  out  acknowledged halts since reset, saturating
module syscall_console
    import syscall_console_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic [31:0] display,
    input  logic        halt,
    input  logic        btn_go,
    output logic        GO,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        halted_led,
    output logic [15:0] syscall_count
);

    localparam int PW = $clog2(SCAN_DIV + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    state_t        state;
    state_t        state_nxt;
    logic          halt_q;
    logic          halt_rise;
    logic [31:0]   shown;
    logic [31:0]   shown_nxt;
    logic [15:0]   count_nxt;
    logic          go_nxt;
    logic          btn_press;
    logic          btn_level;
    logic          unused_btn_level;

    logic [PW-1:0] presc;
    logic          scan_tick;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic [3:0]    nib;
    logic          dp_n;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (CLR),
        .btn_raw (btn_go),
        .level   (btn_level),
        .rise    (btn_press)
    );

    assign unused_btn_level = btn_level;

    assign halt_rise  = halt & ~halt_q;
    assign halted_led = (state != ST_RUN);

    // Next-state logic. In RUN a halt rise takes priority and any press in
    // the same cycle is simply dropped (presses are ignored in RUN anyway).
    always_comb begin
        state_nxt = state;
        shown_nxt = shown;
        count_nxt = syscall_count;
        go_nxt    = 1'b0;
        case (state)
            ST_RUN: begin
                shown_nxt = display;
                if (halt_rise) begin
                    state_nxt = ST_HALTED;
                    if (syscall_count != COUNT_MAX) begin
                        count_nxt = syscall_count + 16'd1;
                    end
                end
            end
            ST_HALTED: begin
                if (btn_press) begin
                    go_nxt    = 1'b1;
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!halt) begin
                    state_nxt = ST_RUN;
                end else if (btn_press) begin
                    // Retry: CPU missed the first GO; masked so GO never doubles.
                    go_nxt = ~GO;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Scan index and the digit it selects are computed from next-cycle values
    // so an and seg always change on the same edge as idx (no ghosting).
    assign scan_tick = (presc == PRESC_LAST);
    assign idx_nxt   = scan_tick ? idx + 3'd1 : idx;
    assign nib       = shown_nxt[{idx_nxt, 2'b00} +: 4];
    assign dp_n      = ~((idx_nxt == 3'd0) && (state_nxt != ST_RUN));

    always_ff @(posedge clk) begin
        if (CLR) begin
            state         <= ST_RUN;
            halt_q        <= 1'b0;
            shown         <= '0;
            syscall_count <= '0;
            GO            <= 1'b0;
            presc         <= '0;
            idx           <= '0;
            an            <= 8'hFE;
            seg           <= 8'hC0;
        end else begin
            state         <= state_nxt;
            halt_q        <= halt;
            shown         <= shown_nxt;
            syscall_count <= count_nxt;
            GO            <= go_nxt;
            presc         <= scan_tick ? '0 : presc + PW'(1);
            idx           <= idx_nxt;
            an            <= ~(8'b1 << idx_nxt);
            seg           <= {dp_n, SEG_HEX[nib][6:0]};
        end
    end

endmodule

// File: tb/tb_syscall_console.sv
// Directed bench for syscall_console with a scoreboard queue of expected values.
// Runs with SCAN_DIV=2 and DEBOUNCE_CYCLES=4 so a press yields GO after 7 cycles.
// Every cycle also checks GO never doubles and an stays one-cold.
module tb_syscall_console;

    localparam int SCAN_DIV = 2;
    localparam int DEB      = 4;

    logic        clk = 1'b0;
    logic        CLR;
    logic [31:0] display;
    logic        halt;
    logic        btn_go;
    logic        GO;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        halted_led;
    logic [15:0] syscall_count;

    int          total  = 0;
    int          bad    = 0;
    int          go_cnt = 0;
    logic        go_prev = 1'b0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    syscall_console #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk           (clk),
        .CLR           (CLR),
        .display       (display),
        .halt          (halt),
        .btn_go        (btn_go),
        .GO            (GO),
        .an            (an),
        .seg           (seg),
        .halted_led    (halted_led),
        .syscall_count (syscall_count)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            cmp(tag, obs, e);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_en) begin
            cmp("go_double", {31'd0, GO & go_prev}, 32'd0);
            cmp("an_onecold", $countones(~an), 32'd1);
            if (GO === 1'b1) go_cnt++;
            go_prev = GO;
        end
    endtask

    task automatic press(output int lat);
        btn_go = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (GO !== 1'b1 && lat < 30);
        btn_go = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    task automatic wait_an(input logic [7:0] target);
        int n = 0;
        while (an !== target && n < 40) begin
            tick();
            n++;
        end
        cmp("an_wait", {24'd0, an}, {24'd0, target});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int g0;
        logic [7:0] e_an;

        // 1: reset
        CLR = 1'b1; halt = 1'b0; btn_go = 1'b0; display = 32'h0;
        repeat (2) tick();
        push(0);     chk("rst_go", {31'd0, GO});
        push(8'hFE); chk("rst_an", {24'd0, an});
        push(8'hC0); chk("rst_seg", {24'd0, seg});
        push(0);     chk("rst_count", {16'd0, syscall_count});
        push(0);     chk("rst_halted", {31'd0, halted_led});
        CLR = 1'b0;
        mon_en = 1'b1;
        tick();

        // 2: halt captures the display word, then display changes are ignored
        display = 32'h1234ABCD; halt = 1'b1;
        tick();
        push(1); chk("halt_led", {31'd0, halted_led});
        push(1); chk("halt_count", {16'd0, syscall_count});
        display = 32'h0;
        tick();
        wait_an(8'hFE);
        push(8'h21); chk("frozen_d0", {24'd0, seg});
        wait_an(8'h7F);
        push(8'hF9); chk("frozen_d7", {24'd0, seg});

        // 3: bouncing button gives nothing, a stable hold gives one GO at 7 cycles
        g0 = go_cnt;
        for (int i = 0; i < 12; i++) begin
            btn_go = ((i / 2) % 2) == 0;
            tick();
        end
        push(DEB + 3); press(lat); chk("go_latency", lat);
        push(1);       chk("go_once", go_cnt - g0);
        push(1);       chk("release_led", {31'd0, halted_led});
        halt = 1'b0;
        tick();
        push(0); chk("run_led", {31'd0, halted_led});
        display = 32'hCAFE0001;
        tick();
        wait_an(8'hFE);
        push(8'hF9); chk("run_d0", {24'd0, seg});
        wait_an(8'h7F);
        push(8'hC6); chk("run_d7", {24'd0, seg});

        // 4: presses ignored in RUN; halt rise wins over a same-cycle press
        g0 = go_cnt;
        btn_go = 1'b1;
        repeat (20) tick();
        btn_go = 1'b0;
        repeat (DEB + 4) tick();
        push(0); chk("run_press_go", go_cnt - g0);
        push(0); chk("run_press_led", {31'd0, halted_led});
        btn_go = 1'b1;
        repeat (DEB + 2) tick();
        halt = 1'b1;
        tick();
        push(1); chk("tie_led", {31'd0, halted_led});
        push(2); chk("tie_count", {16'd0, syscall_count});
        btn_go = 1'b0;
        repeat (10) tick();
        push(0); chk("tie_no_go", go_cnt - g0);

        // 5: full scan rotation, two cycles per digit
        wait_an(8'h7F);
        wait_an(8'hFE);
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < 2; j++) begin
                if (!(k == 8 && j == 1)) begin
                    e_an = ~(8'd1 << (k % 8));
                    push({24'd0, e_an});
                    chk("scan_an", {24'd0, an});
                    tick();
                end
            end
        end

        // 6: CLR from HALTED with count 3, then from RELEASE after a retry GO
        push(DEB + 3); press(lat); chk("go_latency2", lat);
        halt = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        push(3); chk("count3", {16'd0, syscall_count});
        push(1); chk("halted3", {31'd0, halted_led});
        CLR = 1'b1;
        tick();
        push(0); chk("clr_h_led", {31'd0, halted_led});
        push(0); chk("clr_h_count", {16'd0, syscall_count});
        push(0); chk("clr_h_go", {31'd0, GO});
        CLR = 1'b0; halt = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        push(DEB + 3); press(lat); chk("go_latency3", lat);
        g0 = go_cnt;
        push(DEB + 3); press(lat); chk("retry_latency", lat);
        push(1);       chk("retry_once", go_cnt - g0);
        push(1);       chk("retry_led", {31'd0, halted_led});
        CLR = 1'b1;
        tick();
        push(0); chk("clr_r_led", {31'd0, halted_led});
        push(0); chk("clr_r_count", {16'd0, syscall_count});
        push(0); chk("clr_r_go", {31'd0, GO});
        CLR = 1'b0; halt = 1'b0;
        repeat (2) tick();

        // 7: saturation near the top of the count
        force dut.syscall_count = 16'hFFFE;
        #1;
        release dut.syscall_count;
        push(16'hFFFE); chk("sat_start", {16'd0, syscall_count});
        halt = 1'b1;
        tick();
        push(16'hFFFF); chk("sat_max", {16'd0, syscall_count});
        push(DEB + 3); press(lat); chk("go_latency4", lat);
        halt = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        push(16'hFFFF); chk("sat_hold", {16'd0, syscall_count});
        push(1);        chk("sat_led", {31'd0, halted_led});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
